dcp_line_buffer: RTL and testbench
==================================

Name: dcp_line_buffer

Overview:
- Raster-to-window converter directly upstream of the transmission estimation stage in the dark-channel-prior dehazing path.
- Accepts one 24-bit RGB pixel per enabled cycle in raster order and stores the previous K-1 image rows.
- Emits, per pixel, a vertical K-pixel column (oldest row first) as the packed in_line word the transmission stage consumes.
- Also emits column/row position and end-of-line/end-of-frame markers for downstream alignment.

Parameters:
- K, 3, window height in rows; only K=3 supported (output packing fixed at 72 bits).
- IMG_W, 640, active pixels per line; minimum 2.
- IMG_H, 480, active lines per frame; minimum K.
- XW, 10, width of column counter; must satisfy 2^XW >= IMG_W.
- YW, 9, width of row counter; must satisfy 2^YW >= IMG_H.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_en  input  1  input pixel valid; no backpressure, sampled every cycle.
- in_sof  input  1  start of frame, qualified by in_en; marks the pixel at (0,0).
- in_pixel  input  24  {R[23:16], G[15:8], B[7:0]}.
- out_en  output  1  out_line valid.
- out_line  output  72  [71:48] row y-2, [47:24] row y-1, [23:0] row y, all at column x.
- out_x  output  XW  column of the emitted column.
- out_y  output  YW  row of the newest pixel in the emitted column.
- out_eol  output  1  high with out_en when out_x == IMG_W-1.
- out_eof  output  1  high with out_en when out_x == IMG_W-1 and out_y == IMG_H-1.

Behaviour:
- Reset (async, rst_n low): out_en, out_eol, out_eof, out_line, out_x, out_y and internal x/y counters all 0. Line memory contents are undefined; they are never emitted before being rewritten.
- Storage: two line memories, L1 (row y-1) and L2 (row y-2), each IMG_W x 24, addressed by x. Read-before-write at the same address in the same cycle.
- Each cycle with in_en=1:
  - L2[x] <= old L1[x]; L1[x] <= in_pixel.
  - Output registers load {old L2[x], old L1[x], in_pixel}, x, y.
  - x increments. At x == IMG_W-1, x wraps to 0 and y increments.
  - At (IMG_W-1, IMG_H-1), x and y both wrap to 0.
- in_en=0: counters, memories and out_line/out_x/out_y hold; out_en/eol/eof are 0 that cycle.
- Latency: exactly 1 cycle from an enabled input pixel to its out_en pulse. One output per input, no gaps inserted.
- out_en = registered (in_en and y >= K-1). Rows 0 and 1 fill the memories only and produce no output. A frame yields (IMG_H-2)*IMG_W outputs.
- out_eol/out_eof are asserted only in cycles where out_en=1.
- in_sof with in_en=1: the pixel is treated as x=0, y=0 regardless of counter state (resync). Counters continue from (1,0).
- in_sof with in_en=0 is ignored.
- A frame that ends early and is followed by in_sof restarts cleanly. Any partially filled rows are discarded, because y restarts at 0 and output is suppressed until row 2.
- Reset mid-frame: everything returns to the reset state immediately. The next frame must begin with in_sof or with pixel (0,0) arriving as the first enabled pixel after reset.
- No arithmetic on pixel data; bits pass unmodified.

Test Plan (IMG_W=4, IMG_H=4, pixel value = {8'(y), 8'(x), 8'hA5}):
- Continuous frame, in_en=1 for 16 cycles:
  - No out_en during rows 0–1.
  - 8 out_en pulses follow.
  - First pulse has out_x=0, out_y=2, out_line={000000A5... i.e. 24'h0000A5, 24'h0100A5, 24'h0200A5}.
- Check on the same frame: out_eol high at outputs 4 and 8; out_eof high only at output 8 (out_x=3, out_y=3, out_line={24'h0103A5, 24'h0203A5, 24'h0303A5}).
- Random in_en gaps, 50% duty, same pixel stream:
  - Identical out_line sequence to the continuous case.
  - Each out_en exactly 1 cycle after its accepting in_en.
  - Outputs hold during gaps.
- Resync: send 6 pixels, then in_sof with pixel (0,0) and a full frame. Outputs match a clean frame; no out_en before the 9th pixel of the new frame.
- Back-to-back frames without gap: the second frame's first out_en has out_y=2, out_x=0, and out_line newest field equal to the second frame's data.
- Assert rst_n low for 1 cycle mid-row 2:
  - All outputs 0 asynchronously.
  - After release, a new frame produces exactly 8 outputs with correct data.

Source files
------------

// File: rtl/dcp_line_buffer.sv
// Raster-to-window line buffer for the dark-channel-prior dehazing path.
// Stores the previous two rows and emits a 3-pixel vertical column per input pixel.
module dcp_line_buffer #(
    parameter int K     = 3,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_en,
    input  logic              in_sof,
    input  logic [23:0]       in_pixel,
    output logic              out_en,
    output logic [71:0]       out_line,
    output logic [XW-1:0]     out_x,
    output logic [YW-1:0]     out_y,
    output logic              out_eol,
    output logic              out_eof
);

    localparam int DATA_W = 24;

    logic [DATA_W-1:0] l1_mem [IMG_W];
    logic [DATA_W-1:0] l2_mem [IMG_W];

    logic [XW-1:0]     x_cnt;
    logic [YW-1:0]     y_cnt;

    logic [XW-1:0]     x_p0;
    logic [YW-1:0]     y_p0;
    logic [DATA_W-1:0] l1_rd_p0;
    logic [DATA_W-1:0] l2_rd_p0;
    logic              last_x_p0;
    logic              last_y_p0;
    logic              vld_p0;

    // Stage p0: resolve the position of the incoming pixel and read both lines.
    // A start-of-frame pixel forces (0,0) regardless of where the counters are.
    always_comb begin
        x_p0      = x_cnt;
        y_p0      = y_cnt;
        if (in_sof) begin
            x_p0 = '0;
            y_p0 = '0;
        end
        l1_rd_p0  = l1_mem[x_p0];
        l2_rd_p0  = l2_mem[x_p0];
        last_x_p0 = (x_p0 == XW'(IMG_W - 1));
        last_y_p0 = (y_p0 == YW'(IMG_H - 1));
        vld_p0    = in_en && (y_p0 >= YW'(K - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (in_en) begin
            if (last_x_p0) begin
                x_cnt <= '0;
                y_cnt <= last_y_p0 ? '0 : y_p0 + YW'(1);
            end else begin
                x_cnt <= x_p0 + XW'(1);
                y_cnt <= y_p0;
            end
        end
    end

    // Line shift: row y-1 ages into row y-2, the new pixel becomes row y-1.
    always_ff @(posedge clk) begin
        if (in_en) begin
            l2_mem[x_p0] <= l1_rd_p0;
            l1_mem[x_p0] <= in_pixel;
        end
    end

    // Stage p1: registered column, position and alignment markers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_en   <= 1'b0;
            out_eol  <= 1'b0;
            out_eof  <= 1'b0;
            out_line <= '0;
            out_x    <= '0;
            out_y    <= '0;
        end else begin
            out_en   <= vld_p0;
            out_eol  <= vld_p0 && last_x_p0;
            out_eof  <= vld_p0 && last_x_p0 && last_y_p0;
            if (in_en) begin
                out_line <= {l2_rd_p0, l1_rd_p0, in_pixel};
                out_x    <= x_p0;
                out_y    <= y_p0;
            end
        end
    end

endmodule

// File: tb/tb_dcp_line_buffer.sv
// Directed/randomized bench for dcp_line_buffer on a 4x4 image with a frame-level reference model.
module tb_dcp_line_buffer;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int XW = 2;
    localparam int YW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_en;
    logic          in_sof;
    logic [23:0]   in_pixel;
    logic          out_en;
    logic [71:0]   out_line;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic          out_eol;
    logic          out_eof;

    dcp_line_buffer #(.K(3), .IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_en    (in_en),
        .in_sof   (in_sof),
        .in_pixel (in_pixel),
        .out_en   (out_en),
        .out_line (out_line),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_eol  (out_eol),
        .out_eof  (out_eof)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [71:0] line;
        logic [1:0]  x;
        logic [1:0]  y;
        logic        eol;
        logic        eof;
    } rec_t;

    rec_t outq[$];
    rec_t ref_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: image position from a linear pixel index, rows kept in a 2-D array.
    int          n_pix;
    logic [23:0] img [H][W];
    logic        exp_en, exp_eol, exp_eof, line_known;
    logic [71:0] exp_line;
    logic [1:0]  exp_x, exp_y;

    function automatic logic [23:0] pix(input int x, input int y, input logic [7:0] tag);
        return {8'(y), 8'(x), tag};
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n_pix      = 0;
        exp_en     = 1'b0;
        exp_eol    = 1'b0;
        exp_eof    = 1'b0;
        exp_line   = '0;
        exp_x      = '0;
        exp_y      = '0;
        line_known = 1'b1;
    endtask

    task automatic step(input logic en, input logic sof, input logic [23:0] p);
        int x, y;
        in_en    = en;
        in_sof   = sof;
        in_pixel = p;
        @(posedge clk);
        #1;
        if (en) begin
            if (sof) n_pix = 0;
            x = n_pix % W;
            y = n_pix / W;
            exp_en  = (y >= 2);
            exp_eol = exp_en && (x == W - 1);
            exp_eof = exp_eol && (y == H - 1);
            if (exp_en) exp_line = {img[y-2][x], img[y-1][x], p};
            line_known = exp_en;
            exp_x = 2'(x);
            exp_y = 2'(y);
            img[y][x] = p;
            n_pix = (n_pix + 1) % (W * H);
        end else begin
            exp_en  = 1'b0;
            exp_eol = 1'b0;
            exp_eof = 1'b0;
        end
        chk("out_en",  72'(out_en),  72'(exp_en));
        chk("out_eol", 72'(out_eol), 72'(exp_eol));
        chk("out_eof", 72'(out_eof), 72'(exp_eof));
        chk("out_x",   72'(out_x),   72'(exp_x));
        chk("out_y",   72'(out_y),   72'(exp_y));
        if (line_known) chk("out_line", out_line, exp_line);
        if (out_en === 1'b1) outq.push_back('{out_line, out_x, out_y, out_eol, out_eof});
    endtask

    task automatic send_frame(input logic sof, input logic gaps, input logic [7:0] tag,
                              output int nout, output int first_idx);
        int start;
        start     = outq.size();
        first_idx = -1;
        for (int i = 0; i < W * H; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++)
                    step(1'b0, 1'($urandom_range(0, 1)), 24'($urandom));
            end
            step(1'b1, sof && (i == 0), pix(i % W, i / W, tag));
            if (first_idx < 0 && outq.size() > start) first_idx = i;
        end
        nout = outq.size() - start;
    endtask

    task automatic cmp_lines(input string tag, input int start);
        for (int k = 0; k < 8; k++) begin
            if (start + k < outq.size()) chk(tag, outq[start+k].line, ref_q[k].line);
            else chk({tag, "_missing"}, 72'd0, 72'd1);
        end
    endtask

    initial begin
        int nout, first, start;
        rst_n    = 1'b0;
        in_en    = 1'b0;
        in_sof   = 1'b0;
        in_pixel = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en",   72'(out_en), 72'd0);
        chk("rst_eol",  72'(out_eol), 72'd0);
        chk("rst_eof",  72'(out_eof), 72'd0);
        chk("rst_line", out_line, 72'd0);
        chk("rst_x",    72'(out_x), 72'd0);
        chk("rst_y",    72'(out_y), 72'd0);
        rst_n = 1'b1;

        // Continuous frame starting with in_sof.
        send_frame(1'b1, 1'b0, 8'hA5, nout, first);
        chk("cont_nout",  72'(nout), 72'd8);
        chk("cont_first", 72'(first), 72'd8);
        if (outq.size() >= 8) begin
            chk("cont_out0_line", outq[0].line, {24'h0000A5, 24'h0100A5, 24'h0200A5});
            chk("cont_out0_x",    72'(outq[0].x), 72'd0);
            chk("cont_out0_y",    72'(outq[0].y), 72'd2);
            chk("cont_out7_line", outq[7].line, {24'h0103A5, 24'h0203A5, 24'h0303A5});
            chk("cont_out7_x",    72'(outq[7].x), 72'd3);
            chk("cont_out7_y",    72'(outq[7].y), 72'd3);
            for (int k = 0; k < 8; k++) begin
                chk("cont_eol", 72'(outq[k].eol), 72'((k % 4) == 3));
                chk("cont_eof", 72'(outq[k].eof), 72'(k == 7));
                ref_q.push_back(outq[k]);
            end
        end else begin
            chk("cont_outq_size", 72'(outq.size()), 72'd8);
        end

        // Same stream with random gaps, relying on the counter wrap.
        start = outq.size();
        send_frame(1'b0, 1'b1, 8'hA5, nout, first);
        chk("gap_nout", 72'(nout), 72'd8);
        cmp_lines("gap_line", start);

        // Resync after a partial frame.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 24'($urandom));
        start = outq.size();
        send_frame(1'b1, 1'b0, 8'hA5, nout, first);
        chk("resync_nout",  72'(nout), 72'd8);
        chk("resync_first", 72'(first), 72'd8);
        cmp_lines("resync_line", start);

        // Back-to-back frames, second frame carries different data.
        send_frame(1'b0, 1'b0, 8'hA5, nout, first);
        start = outq.size();
        send_frame(1'b1, 1'b0, 8'h5A, nout, first);
        chk("b2b_nout", 72'(nout), 72'd8);
        if (outq.size() > start) begin
            chk("b2b_x",      72'(outq[start].x), 72'd0);
            chk("b2b_y",      72'(outq[start].y), 72'd2);
            chk("b2b_newest", 72'(outq[start].line[23:0]), 72'h02005A);
        end else begin
            chk("b2b_missing", 72'(outq.size()), 72'(start + 1));
        end

        // Reset in the middle of row 2.
        for (int i = 0; i < 10; i++) step(1'b1, i == 0, pix(i % W, i / W, 8'h33));
        in_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en",   72'(out_en), 72'd0);
        chk("mid_rst_line", out_line, 72'd0);
        chk("mid_rst_x",    72'(out_x), 72'd0);
        chk("mid_rst_y",    72'(out_y), 72'd0);
        chk("mid_rst_eol",  72'(out_eol), 72'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        start = outq.size();
        send_frame(1'b0, 1'b0, 8'hA5, nout, first);
        chk("post_rst_nout",  72'(nout), 72'd8);
        chk("post_rst_first", 72'(first), 72'd8);
        cmp_lines("post_rst_line", start);

        step(1'b0, 1'b0, 24'd0);
        step(1'b0, 1'b1, 24'hFFFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
